// File: rtl/ctrl_conv_input.sv
// Input-side controller for the convolution engine: streams filter and vector
// elements into F/X memory, then requests a convolution and waits for completion.
module ctrl_conv_input #(
  parameter int F_MEM_SIZE       = 4,
  parameter int X_MEM_SIZE       = 8,
  parameter int X_MEM_ADDR_WIDTH = 3,
  parameter int F_MEM_ADDR_WIDTH = 2,
  parameter int DATA_WIDTH       = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       s_data_x,
  input  logic                        s_valid_x,
  output logic                        s_ready_x,
  input  logic                        new_matrix,
  input  logic                        conv_done,
  output logic                        conv_start,
  output logic [DATA_WIDTH-1:0]       wr_data,
  output logic                        wr_en_f,
  output logic [F_MEM_ADDR_WIDTH-1:0] wr_addr_f,
  output logic                        wr_en_x,
  output logic [X_MEM_ADDR_WIDTH-1:0] wr_addr_x
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_F,
    LOAD_X,
    CONV_WAIT
  } state_t;

  localparam logic [F_MEM_ADDR_WIDTH-1:0] F_LAST = F_MEM_ADDR_WIDTH'(F_MEM_SIZE - 1);
  localparam logic [X_MEM_ADDR_WIDTH-1:0] X_LAST = X_MEM_ADDR_WIDTH'(X_MEM_SIZE - 1);

  state_t                      state;
  state_t                      state_next;
  logic [F_MEM_ADDR_WIDTH-1:0] f_cnt;
  logic [X_MEM_ADDR_WIDTH-1:0] x_cnt;
  logic                        f_valid;
  logic                        xfer;
  logic                        start_with_f;
  logic                        done_ack;

  assign xfer         = s_valid_x && s_ready_x;
  // A frame reuses the stored filter only when one was loaded and no new one is requested.
  assign start_with_f = new_matrix || !f_valid;
  // conv_done counts only once conv_start is visible downstream.
  assign done_ack     = conv_start && conv_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (xfer) state_next = start_with_f ? LOAD_F : LOAD_X;
      LOAD_F:    if (xfer && (f_cnt == F_LAST)) state_next = LOAD_X;
      LOAD_X:    if (xfer && (x_cnt == X_LAST)) state_next = CONV_WAIT;
      CONV_WAIT: if (done_ack) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    s_ready_x = (state != CONV_WAIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      conv_start <= 1'b0;
      wr_en_f    <= 1'b0;
      wr_en_x    <= 1'b0;
      wr_addr_f  <= '0;
      wr_addr_x  <= '0;
      wr_data    <= '0;
      f_cnt      <= '0;
      x_cnt      <= '0;
      f_valid    <= 1'b0;
    end else begin
      wr_en_f    <= 1'b0;
      wr_en_x    <= 1'b0;
      conv_start <= (state == CONV_WAIT) && !done_ack;
      if (xfer) begin
        wr_data <= s_data_x;
        case (state)
          IDLE: begin
            if (start_with_f) begin
              wr_en_f   <= 1'b1;
              wr_addr_f <= '0;
              f_cnt     <= F_MEM_ADDR_WIDTH'(1);
            end else begin
              wr_en_x   <= 1'b1;
              wr_addr_x <= '0;
              x_cnt     <= X_MEM_ADDR_WIDTH'(1);
            end
          end
          LOAD_F: begin
            wr_en_f   <= 1'b1;
            wr_addr_f <= f_cnt;
            if (f_cnt == F_LAST) begin
              f_cnt   <= '0;
              f_valid <= 1'b1;
              x_cnt   <= '0;
            end else begin
              f_cnt <= f_cnt + F_MEM_ADDR_WIDTH'(1);
            end
          end
          LOAD_X: begin
            wr_en_x   <= 1'b1;
            wr_addr_x <= x_cnt;
            if (x_cnt == X_LAST) begin
              x_cnt <= '0;
            end else begin
              x_cnt <= x_cnt + X_MEM_ADDR_WIDTH'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/ctrl_conv_input.md
Name: ctrl_conv_input

Overview:
Input-side controller for the convolution engine. It accepts the AXI-stream input of filter and vector elements, writes them into F memory and X memory, and raises conv_start once both memories hold a complete frame. It then holds off further input until the output-side controller returns a conv_done pulse. This is the stage directly upstream of the output/pipeline controller and provides that controller's conv_start and consumes its conv_done.

Parameters:
F_MEM_SIZE, 4, filter length in elements (>=2)
X_MEM_SIZE, 8, input vector length in elements (>F_MEM_SIZE)
X_MEM_ADDR_WIDTH, 3, X memory address width, $clog2(X_MEM_SIZE)
F_MEM_ADDR_WIDTH, 2, F memory address width, $clog2(F_MEM_SIZE)
DATA_WIDTH, 8, element width

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high reset
s_data_x  in  DATA_WIDTH  input stream element
s_valid_x  in  1  input element valid
s_ready_x  out  1  input element accepted when s_valid_x && s_ready_x
new_matrix  in  1  sampled only on the accepted first element of a frame; 1 = frame begins with a new filter
conv_done  in  1  one-cycle pulse from output controller; convolution complete
conv_start  out  1  level; both memories are full and a convolution is requested
wr_data  out  DATA_WIDTH  registered write data shared by both memories
wr_en_f  out  1  F memory write enable
wr_addr_f  out  F_MEM_ADDR_WIDTH  F memory write address
wr_en_x  out  1  X memory write enable
wr_addr_x  out  X_MEM_ADDR_WIDTH  X memory write address

Behaviour:
- Reset (synchronous, active-high, overrides everything including mid-frame): state=IDLE; s_ready_x=1; conv_start=0; wr_en_f=0; wr_en_x=0; wr_addr_f=0; wr_addr_x=0; wr_data=0; f_cnt=0; x_cnt=0; f_valid=0. A partially loaded frame is discarded.
- Transfer = s_valid_x && s_ready_x in the same cycle. s_ready_x is combinational from state: 1 in IDLE, LOAD_F and LOAD_X; 0 in CONV_WAIT.
- Write latency is 1 cycle. A transfer at edge N produces wr_en_*=1 during cycle N+1, with wr_data=s_data_x and the address equal to the element index. With no transfer, both wr_en signals are 0 in the following cycle. Counters and addresses hold under s_valid_x=0 stalls.
- f_valid is set when the last F element is accepted. It stays set until reset.
- State machine:
  - IDLE:
    - On transfer, if new_matrix || !f_valid: element is F[0], f_cnt<=1, go to LOAD_F.
    - On transfer otherwise: element is X[0], x_cnt<=1, go to LOAD_X (the F contents are reused).
  - LOAD_F: each transfer writes F[f_cnt] and increments f_cnt. The transfer with f_cnt==F_MEM_SIZE-1 sets f_valid, clears f_cnt, and goes to LOAD_X with x_cnt=0.
  - LOAD_X: each transfer writes X[x_cnt] and increments x_cnt. The transfer with x_cnt==X_MEM_SIZE-1 clears x_cnt and goes to CONV_WAIT.
  - CONV_WAIT:
    - The last X write (wr_en_x=1, wr_addr_x=X_MEM_SIZE-1) occurs in the first CONV_WAIT cycle.
    - conv_start rises in the next cycle, i.e. 2 cycles after the last accepted element. It stays 1 until conv_done is sampled high.
    - On conv_done=1: conv_start<=0 and state<=IDLE on the same edge.
    - The downstream controller ignores conv_start while its conv_done is high, so no restart occurs.
- conv_done outside CONV_WAIT is ignored. conv_done in the first CONV_WAIT cycle, before conv_start is asserted, is also ignored.
- new_matrix is ignored on every transfer except the first of a frame.
- Counters compare against SIZE-1 only and never wrap past the memory size. Address widths are exact, and no arithmetic overflow is possible.
- Simultaneous reset and conv_done: reset wins.

Test Plan:
- Reset values: assert reset for 2 cycles mid-LOAD_X (after 3 X elements) -> the next cycle shows s_ready_x=1, conv_start=0, both wr_en=0. A following new_matrix=0 frame still loads 4 F elements, because f_valid was cleared.
- Full frame, continuous valid, new_matrix=1, data 1..12 -> wr_en_f for 4 cycles with addr 0..3 and data 1..4. Then wr_en_x for 8 cycles with addr 0..7 and data 5..12. conv_start=1 exactly 2 cycles after the 12th transfer. s_ready_x=0 from the cycle after the 12th transfer.
- Reuse filter: after the first frame's conv_done, send a frame with new_matrix=0 and 8 elements -> zero wr_en_f pulses, wr_en_x addr 0..7, conv_start asserted again.
- First frame after reset with new_matrix=0 -> treated as a new filter: 4 F writes then 8 X writes.
- Backpressure gaps: s_valid_x toggling 1,0,0,1,... -> addresses advance only on transfers, wr_en pulses only one cycle after each transfer, total write count unchanged.
- Done handling: hold conv_start, withhold conv_done for 20 cycles -> conv_start stays 1 and s_ready_x stays 0. Drive a one-cycle conv_done -> conv_start=0 and s_ready_x=1 next cycle. A stray conv_done in IDLE causes no state change.
